lane_traffic: RTL and testbench

// Parametrised multi-lane road generator for the Frogger LED matrix. Drives NUM_LANES

---
 rtl/lane_traffic_if.sv | 23 ++
 rtl/lane_traffic.sv | 95 +++++++++
 tb/tb_lane_traffic.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/lane_traffic_if.sv
// Bundle between the game logic and the road generator: tick/pause controls and
// frog position in, the lane frame and collision flag out.
interface lane_traffic_if #(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16
);
    logic                          step;
    logic                          enable;
    logic [$clog2(HEIGHT)-1:0]     frog_row;
    logic [$clog2(WIDTH)-1:0]      frog_col;
    logic [HEIGHT-1:0][WIDTH-1:0]  RedPixels;
    logic                          hit;

    modport master (
        output step, enable, frog_row, frog_col,
        input  RedPixels, hit
    );

    modport slave (
        input  step, enable, frog_row, frog_col,
        output RedPixels, hit
    );
endinterface

// File: rtl/lane_traffic.sv
// Multi-lane road generator: each lane holds a rotating car pattern advanced by
// its own tick divider, mapped onto consecutive frame rows, plus a sticky
// frog/car collision flag computed from the currently displayed frame.
module lane_traffic #(
    parameter int WIDTH     = 16,
    parameter int HEIGHT    = 16,
    parameter int NUM_LANES = 3,
    parameter int BASE_ROW  = 8,
    parameter int SPACING   = 3
) (
    input  logic           clk,
    input  logic           RST,
    lane_traffic_if.slave  bus
);
    // Divider counts up to NUM_LANES-1 (slowest lane period is NUM_LANES ticks).
    localparam int CW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic [NUM_LANES-1:0][WIDTH-1:0] lanes;
    logic [HEIGHT-1:0][WIDTH-1:0]    frame;
    logic                            lane_hit;
    logic                            hit_q;
    logic                            adv;

    function automatic logic [WIDTH-1:0] rot_left(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], v[WIDTH-1]};
    endfunction

    function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] v);
        return {v[0], v[WIDTH-1:1]};
    endfunction

    // Initial car layout: cars every SPACING columns, staggered by lane index.
    function automatic logic [WIDTH-1:0] reset_pattern(input int lane);
        logic [WIDTH-1:0] p;
        p = '0;
        for (int j = 0; j < WIDTH; j++) begin
            p[j] = (((j + lane) % SPACING) == 0);
        end
        return p;
    endfunction

    assign adv = bus.step & bus.enable;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [WIDTH-1:0] lane_q;
        logic [CW-1:0]    cnt_q;

        // Lane i divides ticks by i+1; even lanes drift left, odd lanes right.
        always_ff @(posedge clk) begin
            if (RST) begin
                lane_q <= reset_pattern(i);
                cnt_q  <= '0;
            end else if (adv) begin
                if (cnt_q == CW'(i)) begin
                    lane_q <= ((i % 2) == 0) ? rot_left(lane_q) : rot_right(lane_q);
                    cnt_q  <= '0;
                end else begin
                    cnt_q  <= cnt_q + 1'b1;
                end
            end
        end

        assign lanes[i] = lane_q;
    end

    // Place lanes on their rows; every other row of the frame stays dark.
    always_comb begin
        frame = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            frame[BASE_ROW + i] = lanes[i];
        end
    end

    // Car under the frog in the displayed frame; non-lane or out-of-range positions never hit.
    always_comb begin
        lane_hit = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if ((int'(bus.frog_row) == (BASE_ROW + i)) && (int'(bus.frog_col) < WIDTH)) begin
                lane_hit = lanes[i][bus.frog_col];
            end
        end
    end

    // Sticky collision flag, cleared only by reset; also evaluated while paused.
    always_ff @(posedge clk) begin
        if (RST) begin
            hit_q <= 1'b0;
        end else if (lane_hit) begin
            hit_q <= 1'b1;
        end
    end

    assign bus.RedPixels = frame;
    assign bus.hit       = hit_q;
endmodule

// File: tb/tb_lane_traffic.sv
// Bench for lane_traffic: a closed-form model (rotation count derived from the
// number of accepted ticks) checked every cycle, plus hand-computed literals.
module tb_lane_traffic;
    localparam int W  = 16;
    localparam int H  = 16;
    localparam int NL = 3;
    localparam int BR = 8;
    localparam int SP = 3;

    logic clk = 1'b0;
    logic RST = 1'b1;
    bit   chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    // model state: ticks accepted since reset, sticky hit
    int   m_ticks = 0;
    bit   m_hit = 1'b0;

    lane_traffic_if #(.WIDTH(W), .HEIGHT(H)) bus ();

    lane_traffic #(
        .WIDTH(W), .HEIGHT(H), .NUM_LANES(NL), .BASE_ROW(BR), .SPACING(SP)
    ) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Row r of the frame after t accepted ticks: lane i has rotated t/(i+1) times.
    function automatic logic [W-1:0] model_row(input int t, input int r);
        logic [W-1:0] p;
        int i, k;
        p = '0;
        if (r < BR || r >= BR + NL) return p;
        i = r - BR;
        for (int j = 0; j < W; j++) p[j] = (((j + i) % SP) == 0);
        k = (t / (i + 1)) % W;
        for (int s = 0; s < k; s++) begin
            if ((i % 2) == 0) p = {p[W-2:0], p[W-1]};
            else              p = {p[0], p[W-1:1]};
        end
        return p;
    endfunction

    always @(posedge clk) begin
        if (RST) begin
            m_ticks <= 0;
            m_hit   <= 1'b0;
        end else begin
            if (model_row(m_ticks, int'(bus.frog_row))[bus.frog_col]) m_hit <= 1'b1;
            if (bus.step && bus.enable) m_ticks <= m_ticks + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [W-1:0] exp_r;
            bit frame_ok;
            frame_ok = 1'b1;
            for (int r = 0; r < H; r++) begin
                exp_r = model_row(m_ticks, r);
                if (bus.RedPixels[r] !== exp_r) begin
                    frame_ok = 1'b0;
                    $display("FAIL frame row %0d: got %h expected %h (ticks %0d) at %0t",
                             r, bus.RedPixels[r], exp_r, m_ticks, $time);
                end
            end
            n_checks++;
            if (!frame_ok) n_fail++;
            n_checks++;
            if (bus.hit !== m_hit) begin
                n_fail++;
                $display("FAIL hit: got %b expected %b at %0t", bus.hit, m_hit, $time);
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock with the given step/enable applied at the edge; returns 2 time units after it.
    task automatic cyc(input logic s, input logic e);
        bus.step   = s;
        bus.enable = e;
        @(posedge clk);
        #2;
        bus.step = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cyc(1'b0, 1'b1);
        RST = 1'b0;
    endtask

    initial begin
        bus.step     = 1'b0;
        bus.enable   = 1'b1;
        bus.frog_row = '0;
        bus.frog_col = '0;
        repeat (2) @(posedge clk);
        #2;
        RST    = 1'b0;
        chk_en = 1'b1;

        // reset layout
        chk("rst row8",  bus.RedPixels[8],  16'h9249);
        chk("rst row9",  bus.RedPixels[9],  16'h4924);
        chk("rst row10", bus.RedPixels[10], 16'h2492);
        chk("rst row0",  bus.RedPixels[0],  16'h0000);
        chk("rst row7",  bus.RedPixels[7],  16'h0000);
        chk("rst row11", bus.RedPixels[11], 16'h0000);
        chk("rst hit",   {15'd0, bus.hit},  16'h0000);

        // per-lane dividers and directions
        cyc(1'b1, 1'b1);
        chk("s1 row8",  bus.RedPixels[8],  16'h2493);
        chk("s1 row9",  bus.RedPixels[9],  16'h4924);
        chk("s1 row10", bus.RedPixels[10], 16'h2492);
        cyc(1'b1, 1'b1);
        chk("s2 row9",  bus.RedPixels[9],  16'h2492);
        cyc(1'b1, 1'b1);
        chk("s3 row10", bus.RedPixels[10], 16'h4924);
        chk("s3 row8",  bus.RedPixels[8],  16'h924C);

        // pause ignores step
        do_reset();
        repeat (5) cyc(1'b1, 1'b0);
        chk("pause row8", bus.RedPixels[8], 16'h9249);
        cyc(1'b1, 1'b1);
        chk("resume row8", bus.RedPixels[8], 16'h2493);
        chk("resume row9", bus.RedPixels[9], 16'h4924);

        // collision at reset position, sticky through steps
        bus.frog_row = 4'd8;
        bus.frog_col = 4'd0;
        do_reset();
        chk("hit pre", {15'd0, bus.hit}, 16'h0000);
        cyc(1'b0, 1'b1);
        chk("hit set", {15'd0, bus.hit}, 16'h0001);
        bus.frog_row = 4'd3;
        repeat (3) cyc(1'b1, 1'b1);
        chk("hit sticky", {15'd0, bus.hit}, 16'h0001);

        // collision appears only after the car arrives
        bus.frog_row = 4'd0;
        do_reset();
        bus.frog_row = 4'd8;
        bus.frog_col = 4'd1;
        cyc(1'b0, 1'b1);
        chk("miss col1", {15'd0, bus.hit}, 16'h0000);
        cyc(1'b1, 1'b1);
        chk("miss pre-frame", {15'd0, bus.hit}, 16'h0000);
        cyc(1'b0, 1'b1);
        chk("hit col1", {15'd0, bus.hit}, 16'h0001);

        // non-lane rows never hit, also while paused
        bus.frog_row = 4'd3;
        bus.frog_col = 4'd0;
        do_reset();
        repeat (6) cyc(1'b1, 1'b1);
        bus.frog_row = 4'd11;
        repeat (4) cyc(1'b0, 1'b0);
        chk("no hit off-lane", {15'd0, bus.hit}, 16'h0000);

        // reset wins over a simultaneous step
        bus.frog_row = 4'd0;
        RST = 1'b1;
        cyc(1'b1, 1'b1);
        RST = 1'b0;
        chk("rst+step row8",  bus.RedPixels[8],  16'h9249);
        chk("rst+step row9",  bus.RedPixels[9],  16'h4924);
        chk("rst+step row10", bus.RedPixels[10], 16'h2492);
        cyc(1'b1, 1'b1);
        chk("cnt cleared row9", bus.RedPixels[9], 16'h4924);

        // long run: 48 ticks from reset
        do_reset();
        repeat (48) cyc(1'b1, 1'b1);
        chk("48 row8",  bus.RedPixels[8],  16'h9249);
        chk("48 row9",  bus.RedPixels[9],  16'h2449);
        chk("48 row10", bus.RedPixels[10], 16'h2492);

        // pause with frog on a car still detects
        bus.frog_row = 4'd10;
        bus.frog_col = 4'd1;
        cyc(1'b1, 1'b0);
        chk("paused hit", {15'd0, bus.hit}, 16'h0001);

        repeat (2) cyc(1'b0, 1'b1);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
